exec_unit: RTL and testbench

Parametrised execute stage for the core pipeline: sits between decode and memory access, performs ALU, multiply and iterative divide operations, computes branch/jump targets, and forwards memory/writeback sideband. Unlike the previous fixed-latency stage, it uses a valid/ready handshake on both sides. It supports a multi-cycle radix-2 divider and a configurable post-redirect flush window that discards wrong-path instructions.

---
 rtl/exec_pkg.sv | 49 ++++
 rtl/exec_unit_div.sv | 100 ++++++++++
 rtl/exec_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_exec_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings, FSM states and sideband bundle for the execute stage.
package exec_pkg;

    // ALU encodings 12..15 are unused and report unknown_op.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_SEQ   = 4'd10,
        ALU_PASSB = 4'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        MUL_NONE   = 4'd0,
        MUL_MUL    = 4'd1,
        MUL_MULH   = 4'd2,
        MUL_MULHSU = 4'd3,
        MUL_MULHU  = 4'd4,
        MUL_DIV    = 4'd5,
        MUL_DIVU   = 4'd6,
        MUL_REM    = 4'd7,
        MUL_REMU   = 4'd8
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // wdata is carried separately because its width follows XLEN.
    typedef struct packed {
        logic       mem_to_reg;
        logic       we;
        logic       re;
        logic       reg_we;
        logic [1:0] bytes;
        logic [4:0] rd;
        logic       unsigned_flag;
    } exec_side_t;

endpackage

// File: rtl/exec_unit_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, sign fix-up on the way out,
// plus combinational detection of divide-by-zero and signed overflow.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            ack,
    input  logic            is_signed,
    input  logic            want_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                   input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = {r, q[XLEN-1]};
        diff = {1'b0, sh[XLEN-1:0]} - {1'b0, d};
        if (sh[XLEN] || !diff[XLEN])
            div_step = {diff[XLEN-1:0], q[XLEN-2:0], 1'b1};
        else
            div_step = {sh[XLEN-1:0], q[XLEN-2:0], 1'b0};
    endfunction

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, neg_q_q, neg_r_q, rem_sel_q;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs, sr, sq, sd, q_fix, r_fix;
    logic [2*XLEN-1:0] nxt;

    assign a_neg = is_signed & dividend[XLEN-1];
    assign b_neg = is_signed & divisor[XLEN-1];
    assign a_abs = a_neg ? -dividend : dividend;
    assign b_abs = b_neg ? -divisor : divisor;

    assign special = (divisor == '0) || (is_signed && dividend == MIN && (&divisor));
    assign special_result = (divisor == '0) ? (want_rem ? dividend : '1)
                                            : (want_rem ? '0 : MIN);

    // The first step is folded into the start cycle so the last bit lands on cycle XLEN.
    always_comb begin
        if (start) begin
            sr = '0;
            sq = a_abs;
            sd = b_abs;
        end else begin
            sr = rem_q;
            sq = quo_q;
            sd = dvs_q;
        end
    end
    assign nxt = div_step(sr, sq, sd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (start) begin
            busy_q         <= 1'b1;
            cnt_q          <= CW'(XLEN-1);
            {rem_q, quo_q} <= nxt;
            dvs_q          <= b_abs;
            neg_q_q        <= a_neg ^ b_neg;
            neg_r_q        <= a_neg;
            rem_sel_q      <= want_rem;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                {rem_q, quo_q} <= nxt;
                cnt_q          <= cnt_q - CW'(1);
            end else if (ack) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign q_fix  = neg_q_q ? -quo_q : quo_q;
    assign r_fix  = neg_r_q ? -rem_q : rem_q;
    assign result = rem_sel_q ? r_fix : q_fix;
    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == '0);

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, multiply, iterative divide and branch target with valid/ready
// handshakes on both sides and a wrong-path flush window after a redirect.
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter bit DIV_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [3:0]      mul_op,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_value,
    input  logic            branch_en,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic            unsigned_flag,
    input  logic            mem_to_reg,
    input  logic            we,
    input  logic            re,
    input  logic            reg_we,
    input  logic [1:0]      bytes,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_unknown_op,
    output logic [XLEN-1:0] addr_out,
    output logic            addr_out_en,
    output logic            flush,
    output logic            mem_to_reg_out,
    output logic            we_out,
    output logic            re_out,
    output logic            reg_we_out,
    output logic [1:0]      bytes_out,
    output logic [XLEN-1:0] wdata_out,
    output logic [4:0]      rd_out,
    output logic            unsigned_flag_out
);
    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_n;
    logic [2:0]      cnt_q, cnt_n;
    logic            slot_free, fire, is_div_op, redirect;
    logic            load, load_div, div_start, div_busy, div_done, div_special;
    logic [XLEN-1:0] div_special_res, div_res, alu_res, exec_res, target;
    logic            alu_unk, exec_unk;
    logic [SHW-1:0]  shamt;
    logic            mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_ext_a, mul_ext_b, mul_prod;
    exec_side_t      in_side, side_q, dside_q;
    logic [XLEN-1:0] wdata_q, dwdata_q;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == ST_IDLE && slot_free) || (state_q == ST_FLUSH);
    assign fire      = in_valid && in_ready;
    assign flush     = (state_q == ST_FLUSH);
    assign is_div_op = (mul_op == MUL_DIV) || (mul_op == MUL_DIVU) ||
                       (mul_op == MUL_REM) || (mul_op == MUL_REMU);
    assign shamt     = alu_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_unk = 1'b0;
        case (alu_op)
            ALU_ADD:   alu_res = alu_a + alu_b;
            ALU_SUB:   alu_res = alu_a - alu_b;
            ALU_AND:   alu_res = alu_a & alu_b;
            ALU_OR:    alu_res = alu_a | alu_b;
            ALU_XOR:   alu_res = alu_a ^ alu_b;
            ALU_SLL:   alu_res = alu_a << shamt;
            ALU_SRL:   alu_res = alu_a >> shamt;
            ALU_SRA:   alu_res = $signed(alu_a) >>> shamt;
            ALU_SLT:   alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU:  alu_res = XLEN'(alu_a < alu_b);
            ALU_SEQ:   alu_res = XLEN'(alu_a == alu_b);
            ALU_PASSB: alu_res = alu_b;
            default:   alu_unk = 1'b1;
        endcase
    end

    // One shared multiplier; operand extension picks the signedness of each side.
    assign mul_sa    = (mul_op == MUL_MULH) || (mul_op == MUL_MULHSU);
    assign mul_sb    = (mul_op == MUL_MULH);
    assign mul_ext_a = {{XLEN{mul_sa & alu_a[XLEN-1]}}, alu_a};
    assign mul_ext_b = {{XLEN{mul_sb & alu_b[XLEN-1]}}, alu_b};
    assign mul_prod  = mul_ext_a * mul_ext_b;

    always_comb begin
        exec_res = alu_res;
        exec_unk = alu_unk;
        case (mul_op)
            MUL_NONE: begin end
            MUL_MUL: begin
                exec_res = mul_prod[XLEN-1:0];
                exec_unk = 1'b0;
            end
            MUL_MULH, MUL_MULHSU, MUL_MULHU: begin
                exec_res = mul_prod[2*XLEN-1:XLEN];
                exec_unk = 1'b0;
            end
            MUL_DIV, MUL_DIVU, MUL_REM, MUL_REMU: begin
                exec_res = div_special_res;
                exec_unk = !DIV_EN;
            end
            default: exec_unk = 1'b1;
        endcase
        if (jal_en || jalr_en)
            exec_res = pc + XLEN'(4);
        if (exec_unk)
            exec_res = '0;
    end

    assign target   = jalr_en ? ((alu_a + imm_value) & ~XLEN'(1)) : (pc + imm_value);
    assign redirect = jal_en || jalr_en || (branch_en && alu_res[0]);

    always_comb begin
        in_side.mem_to_reg    = mem_to_reg;
        in_side.we            = we;
        in_side.re            = re;
        in_side.reg_we        = reg_we;
        in_side.bytes         = bytes;
        in_side.rd            = rd;
        in_side.unsigned_flag = unsigned_flag;
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (div_start),
        .ack            (load_div),
        .is_signed      ((mul_op == MUL_DIV) || (mul_op == MUL_REM)),
        .want_rem       ((mul_op == MUL_REM) || (mul_op == MUL_REMU)),
        .dividend       (alu_a),
        .divisor        (alu_b),
        .busy           (div_busy),
        .done           (div_done),
        .special        (div_special),
        .special_result (div_special_res),
        .result         (div_res)
    );

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        load      = 1'b0;
        load_div  = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    if (is_div_op && DIV_EN && !div_special) begin
                        div_start = 1'b1;
                        state_n   = ST_DIV;
                    end else begin
                        load = 1'b1;
                        if (redirect) begin
                            state_n = ST_FLUSH;
                            cnt_n   = 3'(FLUSH_CYCLES);
                        end
                    end
                end
            end
            ST_DIV: begin
                if (div_done && slot_free) begin
                    load_div = 1'b1;
                    state_n  = ST_IDLE;
                end else if (!div_busy) begin
                    state_n = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 3'd0) state_n = ST_IDLE;
                else               cnt_n   = cnt_q - 3'd1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Output slot: a new load always wins over the downstream consume of the old one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            alu_result     <= '0;
            alu_unknown_op <= 1'b0;
            addr_out       <= '0;
            addr_out_en    <= 1'b0;
            side_q         <= '0;
            wdata_q        <= '0;
            dside_q        <= '0;
            dwdata_q       <= '0;
        end else begin
            if (load) begin
                out_valid      <= 1'b1;
                alu_result     <= exec_res;
                alu_unknown_op <= exec_unk;
                addr_out       <= target;
                addr_out_en    <= redirect;
                side_q         <= in_side;
                wdata_q        <= wdata;
            end else if (load_div) begin
                out_valid      <= 1'b1;
                alu_result     <= div_res;
                alu_unknown_op <= 1'b0;
                addr_out       <= '0;
                addr_out_en    <= 1'b0;
                side_q         <= dside_q;
                wdata_q        <= dwdata_q;
            end else begin
                addr_out_en <= 1'b0;
                if (out_ready) out_valid <= 1'b0;
            end
            if (div_start) begin
                dside_q  <= in_side;
                dwdata_q <= wdata;
            end
        end
    end

    assign mem_to_reg_out    = side_q.mem_to_reg;
    assign we_out            = side_q.we;
    assign re_out            = side_q.re;
    assign reg_we_out        = side_q.reg_we;
    assign bytes_out         = side_q.bytes;
    assign rd_out            = side_q.rd;
    assign unsigned_flag_out = side_q.unsigned_flag;
    assign wdata_out         = wdata_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit (XLEN=32, FLUSH_CYCLES=2, DIV_EN=1).
module tb_exec_unit;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [3:0]  alu_op, mul_op;
    logic [31:0] alu_a, alu_b, pc, imm_value, wdata;
    logic        branch_en, jal_en, jalr_en, unsigned_flag;
    logic        mem_to_reg, we, re, reg_we;
    logic [1:0]  bytes;
    logic [4:0]  rd;
    logic        out_valid, out_ready;
    logic [31:0] alu_result, addr_out, wdata_out;
    logic        alu_unknown_op, addr_out_en, flush;
    logic        mem_to_reg_out, we_out, re_out, reg_we_out, unsigned_flag_out;
    logic [1:0]  bytes_out;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exec_unit #(.XLEN(32), .FLUSH_CYCLES(2), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .mul_op(mul_op),
        .alu_a(alu_a), .alu_b(alu_b), .pc(pc), .imm_value(imm_value),
        .branch_en(branch_en), .jal_en(jal_en), .jalr_en(jalr_en), .unsigned_flag(unsigned_flag),
        .mem_to_reg(mem_to_reg), .we(we), .re(re), .reg_we(reg_we),
        .bytes(bytes), .wdata(wdata), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .alu_unknown_op(alu_unknown_op),
        .addr_out(addr_out), .addr_out_en(addr_out_en), .flush(flush),
        .mem_to_reg_out(mem_to_reg_out), .we_out(we_out), .re_out(re_out),
        .reg_we_out(reg_we_out), .bytes_out(bytes_out), .wdata_out(wdata_out),
        .rd_out(rd_out), .unsigned_flag_out(unsigned_flag_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] aop, input logic [3:0] mop,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        in_valid = 1'b1; alu_op = aop; mul_op = mop; alu_a = a; alu_b = b; rd = r;
        jal_en = 1'b0; jalr_en = 1'b0; branch_en = 1'b0; pc = '0; imm_value = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; mul_op = '0; alu_a = '0; alu_b = '0; pc = '0; imm_value = '0;
        branch_en = 1'b0; jal_en = 1'b0; jalr_en = 1'b0; unsigned_flag = 1'b0;
        mem_to_reg = 1'b0; we = 1'b0; re = 1'b0; reg_we = 1'b0; bytes = '0; wdata = '0; rd = '0;
        #13;
        n_cmp++;
        if ({out_valid, addr_out_en, flush, alu_unknown_op, mem_to_reg_out, we_out, re_out,
             reg_we_out, unsigned_flag_out} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000000", {out_valid, addr_out_en, flush,
                     alu_unknown_op, mem_to_reg_out, we_out, re_out, reg_we_out, unsigned_flag_out});
        end
        n_cmp++;
        if ({alu_result, addr_out, wdata_out, bytes_out, rd_out} !== 103'b0) begin
            n_bad++;
            $display("FAIL reset_data: result=%h addr=%h wdata=%h bytes=%b rd=%0d want all 0",
                     alu_result, addr_out, wdata_out, bytes_out, rd_out);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(ALU_ADD, 4'd0, 32'd5, 32'd7, 5'd1);
        we = 1'b1; bytes = 2'd2; wdata = 32'hCAFE_0001; unsigned_flag = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL add_in_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0; we = 1'b0; bytes = '0; wdata = '0; unsigned_flag = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_result !== 32'd12) begin
            n_bad++;
            $display("FAIL add_result: valid=%b result=%h want valid=1 result=0000000c", out_valid, alu_result);
        end
        n_cmp++;
        if (rd_out !== 5'd1 || we_out !== 1'b1 || bytes_out !== 2'd2 || wdata_out !== 32'hCAFE_0001 ||
            unsigned_flag_out !== 1'b1) begin
            n_bad++;
            $display("FAIL add_sideband: rd=%0d we=%b bytes=%0d wdata=%h uns=%b want 1 1 2 cafe0001 1",
                     rd_out, we_out, bytes_out, wdata_out, unsigned_flag_out);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_consumed: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        for (int i = 0; i < 10; i++) begin
            drive(ALU_ADD, 4'd0, 32'(i), 32'd100, 5'(i));
            #1;
            if (in_ready !== 1'b1) stalls++;
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || alu_result !== 32'(i + 100) || rd_out !== 5'(i)) begin
                n_bad++;
                $display("FAIL b2b_%0d: valid=%b result=%0d rd=%0d want 1 %0d %0d",
                         i, out_valid, alu_result, rd_out, i + 100, i);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (stalls !== 0) begin
            n_bad++;
            $display("FAIL b2b_stalls: got %0d want 0", stalls);
        end
        step();
    endtask

    task automatic test_alu_ops();
        logic [3:0]  aop [11];
        logic [3:0]  mop [11];
        logic [31:0] va  [11];
        logic [31:0] vb  [11];
        logic [31:0] exp [11];
        logic        unk [11];
        aop = '{ALU_SUB, ALU_SRA, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_AND, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, 4'd15};
        mop = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd0};
        va  = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_F0F0,
                32'd6, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3};
        vb  = '{32'd7, 32'd4, 32'd4, 32'd1, 32'd1, 32'h0000_FF00,
                32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd4};
        exp = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'h0000_F000,
                32'd42, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
        unk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            drive(aop[i], mop[i], va[i], vb[i], 5'(i + 10));
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || alu_result !== exp[i] || alu_unknown_op !== unk[i] ||
                rd_out !== 5'(i + 10)) begin
                n_bad++;
                $display("FAIL op_%0d: valid=%b result=%h unk=%b rd=%0d want 1 %h %b %0d",
                         i, out_valid, alu_result, alu_unknown_op, rd_out, exp[i], unk[i], i + 10);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_divide();
        logic [3:0]  mop [2];
        logic [31:0] va  [2];
        logic [31:0] exp [2];
        mop = '{4'd6, 4'd7};
        va  = '{32'd100, 32'hFFFF_FF9C};
        exp = '{32'd14, 32'hFFFF_FFFE};
        for (int i = 0; i < 2; i++) begin
            int bad = 0;
            drive(ALU_ADD, mop[i], va[i], 32'd7, 5'd5);
            step();
            in_valid = 1'b0;
            for (int k = 1; k <= 32; k++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
                step();
            end
            n_cmp++;
            if (bad !== 0) begin
                n_bad++;
                $display("FAIL div_%0d_busy: %0d cycles with in_ready/out_valid high, want 0", i, bad);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || alu_result !== exp[i] || rd_out !== 5'd5) begin
                n_bad++;
                $display("FAIL div_%0d_result: valid=%b result=%h rd=%0d want 1 %h 5",
                         i, out_valid, alu_result, rd_out, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_div_special();
        logic [3:0]  mop [4];
        logic [31:0] va  [4];
        logic [31:0] vb  [4];
        logic [31:0] exp [4];
        mop = '{4'd5, 4'd5, 4'd7, 4'd8};
        va  = '{32'd9, 32'h8000_0000, 32'h8000_0000, 32'd9};
        vb  = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        exp = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd9};
        for (int i = 0; i < 4; i++) begin
            drive(ALU_ADD, mop[i], va[i], vb[i], 5'(i + 20));
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || alu_result !== exp[i] || rd_out !== 5'(i + 20)) begin
                n_bad++;
                $display("FAIL divspec_%0d: valid=%b result=%h rd=%0d want 1 %h %0d",
                         i, out_valid, alu_result, rd_out, exp[i], i + 20);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_jal();
        int fl = 0, ae = 0, ov = 0, rdy_bad = 0;
        drive(ALU_ADD, 4'd0, 32'd0, 32'd0, 5'd3);
        jal_en = 1'b1; pc = 32'h100; imm_value = 32'h20;
        step();
        n_cmp++;
        if (addr_out !== 32'h120 || addr_out_en !== 1'b1 || flush !== 1'b1) begin
            n_bad++;
            $display("FAIL jal_redirect: addr=%h en=%b flush=%b want 00000120 1 1", addr_out, addr_out_en, flush);
        end
        drive(ALU_ADD, 4'd0, 32'h55, 32'd0, 5'd9);
        for (int k = 0; k < 6; k++) begin
            if (flush === 1'b1) fl++;
            if (addr_out_en === 1'b1) ae++;
            if (out_valid === 1'b1) ov++;
            if (k < 2 && in_ready !== 1'b1) rdy_bad++;
            step();
            if (k == 1) in_valid = 1'b0;
        end
        n_cmp++;
        if (fl !== 3 || ae !== 1 || ov !== 1 || rdy_bad !== 0) begin
            n_bad++;
            $display("FAIL jal_flush: flush=%0d en=%0d valid=%0d rdy_bad=%0d want 3 1 1 0", fl, ae, ov, rdy_bad);
        end
        n_cmp++;
        if (rd_out !== 5'd3 || flush !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL jal_dropped: rd=%0d flush=%b ready=%b want 3 0 1", rd_out, flush, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        out_ready = 1'b0;
        drive(ALU_ADD, 4'd0, 32'd3, 32'd4, 5'd1);
        step();
        drive(ALU_ADD, 4'd0, 32'd10, 32'd20, 5'd2);
        for (int k = 0; k < 5; k++) begin
            #1;
            if (out_valid !== 1'b1 || alu_result !== 32'd7 || rd_out !== 5'd1 || in_ready !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_result !== 32'd30 || rd_out !== 5'd2) begin
            n_bad++;
            $display("FAIL bp_next: valid=%b result=%0d rd=%0d want 1 30 2", out_valid, alu_result, rd_out);
        end
        step();
    endtask

    task automatic test_reset_mid_div();
        int bad = 0;
        drive(ALU_ADD, 4'd6, 32'd100, 32'd7, 5'd4);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL middiv_busy: in_ready=%b want 0", in_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || alu_result !== 32'd0 || rd_out !== 5'd0 || flush !== 1'b0 ||
            in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL middiv_reset: valid=%b result=%h rd=%0d flush=%b ready=%b want 0 0 0 0 1",
                     out_valid, alu_result, rd_out, flush, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        drive(ALU_ADD, 4'd0, 32'd2, 32'd2, 5'd6);
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_result !== 32'd4 || rd_out !== 5'd6) begin
            n_bad++;
            $display("FAIL middiv_next: valid=%b result=%0d rd=%0d want 1 4 6", out_valid, alu_result, rd_out);
        end
        step();
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL middiv_stale: %0d spurious out_valid cycles, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_alu_ops();
        test_divide();
        test_div_special();
        test_jal();
        test_backpressure();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
